// File: rtl/led_sel_seq.sv
// led_sel_seq: button-driven LED select sequencer.
//
// Synchronizes and debounces two raw push-buttons, then runs an OFF / MANUAL / AUTO mode
// machine that steps a 2-bit LED select code per button press or on a free-running period.
//
// Optional feature macro: LED_SEQ_AUTO_EN. When defined, the AUTO state and its period timer
// are built. When undefined, btn_mode toggles OFF <-> MANUAL only and AUTO_PERIOD is unused.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   btn_next_i  raw asynchronous button, active-high; steps the select code
//   btn_mode_i  raw asynchronous button, active-high; cycles the mode
//   sel_code_o  LED select code (to decoder dataIn)
//   led_on_o    LED enable (to decoder ledOn)
//   mode_o      current mode: 00 OFF, 01 MANUAL, 10 AUTO
module led_sel_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned AUTO_PERIOD     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next_i,
  input  logic       btn_mode_i,
  output logic [1:0] sel_code_o,
  output logic       led_on_o,
  output logic [1:0] mode_o
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (AUTO_PERIOD < 2) begin : g_bad_period
    $error("AUTO_PERIOD must be at least 2");
  end

  localparam int unsigned    CntW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StOff    = 2'b00,
    StManual = 2'b01,
    StAuto   = 2'b10
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Input path: bit 0 = next button, bit 1 = mode button
  // ---------------------------------------------------------------------------------------------
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      deb_q, deb_d;
  logic [1:0]      deb_prev_q;
  logic [CntW-1:0] cnt_q [2];
  logic [CntW-1:0] cnt_d [2];
  logic            next_p, mode_p;

  assign btn_raw = {btn_mode_i, btn_next_i};

  // The counter only survives consecutive mismatched cycles; the level flips on the cycle
  // after it has seen DEBOUNCE_CYCLES-1 of them and the mismatch still holds.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Rising edges of the debounced levels only; releases are silent.
  assign next_p = deb_q[0] & ~deb_prev_q[0];
  assign mode_p = deb_q[1] & ~deb_prev_q[1];

  // ---------------------------------------------------------------------------------------------
  // Mode machine with registered outputs
  // ---------------------------------------------------------------------------------------------
  state_e     state_q;
  logic [1:0] sel_q;
  logic       led_q;

`ifdef LED_SEQ_AUTO_EN
  localparam int unsigned     TmrW    = $clog2(AUTO_PERIOD);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(AUTO_PERIOD - 1);

  logic [TmrW-1:0] tmr_q;
`endif

  // mode_p always wins: a coincident next_p (or AUTO terminal count) is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      sel_q   <= 2'b00;
      led_q   <= 1'b0;
`ifdef LED_SEQ_AUTO_EN
      tmr_q   <= '0;
`endif
    end else begin
`ifdef LED_SEQ_AUTO_EN
      // Held at zero outside AUTO; the AUTO branch overrides.
      tmr_q <= '0;
`endif
      case (state_q)
        StOff: begin
          if (mode_p) begin
            state_q <= StManual;
            led_q   <= 1'b1;
          end
        end
        StManual: begin
          if (mode_p) begin
`ifdef LED_SEQ_AUTO_EN
            state_q <= StAuto;
            led_q   <= 1'b1;
`else
            state_q <= StOff;
            led_q   <= 1'b0;
`endif
          end else if (next_p) begin
            sel_q <= sel_q + 2'd1;
          end
        end
`ifdef LED_SEQ_AUTO_EN
        StAuto: begin
          if (mode_p) begin
            state_q <= StOff;
            led_q   <= 1'b0;
          end else if (next_p || (tmr_q == TmrLast)) begin
            // A press coinciding with terminal count still steps only once.
            sel_q <= sel_q + 2'd1;
            tmr_q <= '0;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
`endif
        default: begin
          state_q <= StOff;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sel_code_o = sel_q;
  assign led_on_o   = led_q;
  assign mode_o     = state_q;

endmodule

// File: tb/tb_led_sel_seq.sv
// tb_led_sel_seq: self-checking bench for led_sel_seq.
//
// A reference model of the mode/select state is advanced as each button press is driven, and
// the expected outputs are queued with the cycle at which they must be visible. A monitor on
// the falling clock edge pops due entries and compares them against the DUT outputs.
// AUTO-specific scenarios are built only when LED_SEQ_AUTO_EN is defined.
module tb_led_sel_seq;

  localparam int unsigned DebCycles  = 4;
  localparam int unsigned AutoPeriod = 8;
  localparam int          Lat        = 3 + DebCycles;  // press drive -> output update edge
  localparam int          ModeGap    = 30;

  localparam logic [1:0] MOff  = 2'b00;
  localparam logic [1:0] MMan  = 2'b01;
  localparam logic [1:0] MAuto = 2'b10;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_mode = 1'b0;
  logic [1:0] sel_code;
  logic       led_on;
  logic [1:0] mode;

  led_sel_seq #(
    .DEBOUNCE_CYCLES(DebCycles),
    .AUTO_PERIOD    (AutoPeriod)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_next_i(btn_next),
    .btn_mode_i(btn_mode),
    .sel_code_o(sel_code),
    .led_on_o  (led_on),
    .mode_o    (mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [1:0] sel;
    logic       led;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [1:0] m_mode = MOff;
  logic [1:0] m_sel  = 2'b00;
  logic       m_led  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue the current model state as the expected output at cycle c (kept sorted by cycle).
  task automatic expect_at(input int c, input string tag);
    exp_t e;
    int   k;
    e.cyc  = c;
    e.mode = m_mode;
    e.sel  = m_sel;
    e.led  = m_led;
    e.tag  = tag;
    k = sb.size();
    while (k > 0 && sb[k-1].cyc > c) k--;
    sb.insert(k, e);
  endtask

  task automatic model_event(input bit nxt, input bit mde);
    if (mde) begin
      case (m_mode)
        MOff: begin
          m_mode = MMan;
          m_led  = 1'b1;
        end
`ifdef LED_SEQ_AUTO_EN
        MMan: begin
          m_mode = MAuto;
          m_led  = 1'b1;
        end
`endif
        default: begin
          m_mode = MOff;
          m_led  = 1'b0;
        end
      endcase
    end else if (nxt && m_mode != MOff) begin
      m_sel = m_sel + 2'd1;
    end
  endtask

  task automatic model_reset();
    m_mode = MOff;
    m_sel  = 2'b00;
    m_led  = 1'b0;
  endtask

  // Must be called at a falling edge.
  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic press(input bit nxt, input bit mde, input int hold);
    btn_next = nxt;
    btn_mode = mde;
    repeat (hold) @(negedge clk);
    btn_next = 1'b0;
    btn_mode = 1'b0;
  endtask

  // Press, expecting the old state one cycle before the update and the new state on it.
  task automatic do_press(input bit nxt, input bit mde, input int hold, input string tag,
                          input int gap);
    int d;
    d = cyc;
    expect_at(d + Lat - 1, {tag, "_pre"});
    model_event(nxt, mde);
    expect_at(d + Lat, tag);
    press(nxt, mde, hold);
    at_cyc(d + gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mode"}, 32'(mode), 32'(MOff));
    check_eq({tag, "_sel"}, 32'(sel_code), 32'd0);
    check_eq({tag, "_led"}, 32'(led_on), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) check_eq({e.tag, "_missed_cycle"}, 32'(cyc), 32'(e.cyc));
      check_eq({e.tag, "_mode"}, 32'(mode), 32'(e.mode));
      check_eq({e.tag, "_sel"}, 32'(sel_code), 32'(e.sel));
      check_eq({e.tag, "_led"}, 32'(led_on), 32'(e.led));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int r;
    int d;
`ifdef LED_SEQ_AUTO_EN
    int e0;
`endif
    @(negedge clk);

    // Reset held while the buttons chatter.
    for (int i = 0; i < 6; i++) begin
      btn_next = i[0];
      btn_mode = ~i[0];
      @(negedge clk);
    end
    check_reset_outputs("rst_hold");
    btn_next = 1'b0;
    btn_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    for (int k = 1; k <= 5; k++) expect_at(r + 10 * k, "idle");
    at_cyc(r + 55);

    // OFF -> MANUAL, then eight clean presses: 01,10,11,00,01,10,11,00.
    do_press(1'b0, 1'b1, 10, "to_manual", ModeGap);
    for (int k = 0; k < 8; k++) do_press(1'b1, 1'b0, 6, "next", 25);

    // A 3-cycle glitch is shorter than the debounce window.
    d = cyc;
    expect_at(d + Lat, "glitch");
    expect_at(d + Lat + 6, "glitch_late");
    press(1'b1, 1'b0, 3);
    at_cyc(d + 25);

    // Both buttons together in MANUAL: mode changes, next is dropped.
    d = cyc;
    do_press(1'b1, 1'b1, 6, "simul", 0);
`ifdef LED_SEQ_AUTO_EN
    e0 = d + Lat;
    expect_at(e0 + 7, "auto1_pre");
    m_sel = 2'd1;
    expect_at(e0 + 8, "auto1");
    expect_at(e0 + 15, "auto2_pre");
    m_sel = 2'd2;
    expect_at(e0 + 16, "auto2");
    // Pulse reaches the machine while the timer reads 5.
    at_cyc(e0 + 15);
    do_press(1'b1, 1'b0, 5, "auto_next", 0);
    expect_at(e0 + 29, "auto3_pre");
    m_sel = 2'd0;
    expect_at(e0 + 30, "auto3");
    expect_at(e0 + 37, "auto4_pre");
    m_sel = 2'd1;
    expect_at(e0 + 38, "auto4");
    m_sel = 2'd2;
    expect_at(e0 + 46, "auto5");
    m_sel = 2'd3;
    expect_at(e0 + 54, "auto6");
    expect_at(e0 + 59, "auto_tmr6");
    // Timer reads 6 here with sel_code = 11.
    at_cyc(e0 + 60);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_auto");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    at_cyc(cyc + 20);
`else
    at_cyc(d + 30);
`endif

    // next is ignored in OFF.
    do_press(1'b1, 1'b0, 6, "off_next", 25);

    // Mode cycling: AUTO build 01,10,00; default build 01,00,01.
    for (int k = 0; k < 3; k++) begin
`ifdef LED_SEQ_AUTO_EN
      if (m_mode == MAuto) m_sel = m_sel + 2'((ModeGap - 1) / AutoPeriod);
`endif
      do_press(1'b0, 1'b1, 10, "mode_cyc", ModeGap);
    end

    // Asynchronous reset mid-operation.
    do_press(1'b1, 1'b0, 6, "pre_rst_next", 25);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    model_reset();

    // A button held through reset release is accepted once debounced.
    @(negedge clk);
    btn_mode = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    expect_at(r + Lat - 1, "held_mode_pre");
    model_event(1'b0, 1'b1);
    expect_at(r + Lat, "held_mode");
    repeat (10) @(negedge clk);
    btn_mode = 1'b0;
    at_cyc(r + 30);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
